// File: rtl/proc_mem_arbiter_if.sv
// Bus bundle between the processor, an external host and a single-port
// synchronous memory, with the arbiter in the middle.
//   Run_in/Run_out  : external run request / run enable to the processor
//   P_*             : processor address, write data, write strobe, idle flag, read data
//   H_*             : host level request, direction, address, data, grant, read-valid
//   M_*             : memory address, write data, write enable, read data (1-cycle latency)
// Modport slave is the arbiter's view; master is the surrounding system's view.
interface proc_mem_arbiter_if;
    logic        Run_in;
    logic        Run_out;
    logic        P_Idle;
    logic [15:0] P_ADDR;
    logic [15:0] P_DOUT;
    logic        P_W;
    logic [15:0] P_DIN;
    logic        H_Req;
    logic        H_W;
    logic [15:0] H_ADDR;
    logic [15:0] H_WDATA;
    logic        H_Gnt;
    logic        H_Valid;
    logic [15:0] H_RDATA;
    logic [15:0] M_ADDR;
    logic [15:0] M_WDATA;
    logic        M_W;
    logic [15:0] M_RDATA;

    modport slave (
        input  Run_in, P_Idle, P_ADDR, P_DOUT, P_W,
        input  H_Req, H_W, H_ADDR, H_WDATA, M_RDATA,
        output Run_out, P_DIN, H_Gnt, H_Valid, H_RDATA,
        output M_ADDR, M_WDATA, M_W
    );

    modport master (
        output Run_in, P_Idle, P_ADDR, P_DOUT, P_W,
        output H_Req, H_W, H_ADDR, H_WDATA, M_RDATA,
        input  Run_out, P_DIN, H_Gnt, H_Valid, H_RDATA,
        input  M_ADDR, M_WDATA, M_W
    );
endinterface

// File: rtl/proc_mem_arbiter.sv
// Shares one synchronous memory between a processor and an external host.
// The processor owns the memory by default (PROC). A host request stops the
// processor (DRAIN) until it reaches its fetch step with no store pending,
// then the host gets up to MAX_BURST single-cycle accesses (HOST).
// After a burst-limited exit a hold-off flag keeps the host out until the
// processor has made progress (P_Idle low) or the run request is removed.
//   Clock  : rising-edge clock
//   Resetn : synchronous, active-low reset
//   bus    : processor / host / memory signals (proc_mem_arbiter_if.slave)
module proc_mem_arbiter #(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    proc_mem_arbiter_if.slave     bus
);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        PROC  = 2'd0,
        DRAIN = 2'd1,
        HOST  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic               r_holdoff;
    logic               r_h_valid;
    logic               w_gnt;
    logic               w_burst_done;
    logic               w_holdoff_clr;

    // Host is granted only while it owns the memory
    assign w_gnt         = (r_state == HOST) && bus.H_Req;
    // This grant is the last one allowed in the current burst
    assign w_burst_done  = w_gnt && (r_count == CNT_W'(MAX_BURST - 1));
    assign w_holdoff_clr = (r_state == PROC) && (!bus.P_Idle || !bus.Run_in);

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PROC: begin
                if (bus.H_Req && !r_holdoff)
                    w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!bus.H_Req)
                    w_state_nxt = PROC;
                else if (bus.P_Idle && !bus.P_W)
                    w_state_nxt = HOST;
            end
            HOST: begin
                if (!bus.H_Req || w_burst_done)
                    w_state_nxt = PROC;
            end
            default: w_state_nxt = PROC;
        endcase
    end

    // State, burst counter, hold-off flag and host read-valid
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state   <= PROC;
            r_count   <= '0;
            r_holdoff <= 1'b0;
            r_h_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_h_valid <= w_gnt && !bus.H_W;

            if (r_state != HOST)
                r_count <= '0;
            else if (w_gnt)
                r_count <= r_count + CNT_W'(1);

            if (w_burst_done)
                r_holdoff <= 1'b1;
            else if (w_holdoff_clr)
                r_holdoff <= 1'b0;
        end
    end

    // Memory port follows the current owner; read data goes to both sides
    assign bus.M_ADDR  = (r_state == HOST) ? bus.H_ADDR  : bus.P_ADDR;
    assign bus.M_WDATA = (r_state == HOST) ? bus.H_WDATA : bus.P_DOUT;
    assign bus.M_W     = (r_state == HOST) ? (w_gnt && bus.H_W) : bus.P_W;
    assign bus.P_DIN   = bus.M_RDATA;
    assign bus.H_RDATA = bus.M_RDATA;
    assign bus.Run_out = (r_state == PROC) && bus.Run_in;
    assign bus.H_Gnt   = w_gnt;
    assign bus.H_Valid = r_h_valid;
endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Randomized bench for proc_mem_arbiter with a behavioural ownership model
// and a 16-word memory that aliases on the low address bits.
module tb_proc_mem_arbiter;
    localparam int unsigned BURST = 8;
    localparam int MD_RUN   = 0;
    localparam int MD_WAIT  = 1;
    localparam int MD_SERVE = 2;

    logic Clock;
    logic Resetn;
    logic tb_mem_clr;
    logic [15:0] tb_mem [0:15];
    logic [15:0] r_mrd;

    proc_mem_arbiter_if bus();

    proc_mem_arbiter #(.MAX_BURST(BURST)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory with one-cycle read latency, read-before-write
    always @(posedge Clock) begin
        r_mrd <= tb_mem[bus.M_ADDR[3:0]];
        if (tb_mem_clr) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= 16'h0000;
        end else if (bus.M_W) begin
            tb_mem[bus.M_ADDR[3:0]] <= bus.M_WDATA;
        end
    end
    assign bus.M_RDATA = r_mrd;

    int n_checks;
    int n_errors;
    int n_gnt_seen;

    // Model state: who owns memory, host grants left, hold-off, pending valid
    int          m_mode;
    int          m_left;
    bit          m_block;
    bit          m_valid;
    logic [15:0] m_mem [0:15];
    logic [15:0] m_rd;
    bit          m_rd_ok;
    bit          m_mem_ok;

    task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it
    task automatic tick(input bit chk);
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic [15:0] rd_next;
        logic        e_w;
        logic        e_gnt;
        logic        e_run;
        bit          serve;
        bit          go;
        @(negedge Clock);
        serve   = (m_mode == MD_SERVE);
        e_gnt   = serve && bus.H_Req;
        e_addr  = serve ? bus.H_ADDR  : bus.P_ADDR;
        e_wdata = serve ? bus.H_WDATA : bus.P_DOUT;
        e_w     = serve ? (e_gnt && bus.H_W) : bus.P_W;
        e_run   = (m_mode == MD_RUN) && bus.Run_in;
        if (bus.H_Gnt) n_gnt_seen++;
        if (chk) begin
            chk_val("run_out", 16'(bus.Run_out), 16'(e_run));
            chk_val("h_gnt",   16'(bus.H_Gnt),   16'(e_gnt));
            chk_val("h_valid", 16'(bus.H_Valid), 16'(m_valid));
            chk_val("m_addr",  bus.M_ADDR,  e_addr);
            chk_val("m_wdata", bus.M_WDATA, e_wdata);
            chk_val("m_w",     16'(bus.M_W), 16'(e_w));
            if (m_rd_ok) begin
                chk_val("p_din",   bus.P_DIN,   m_rd);
                chk_val("h_rdata", bus.H_RDATA, m_rd);
            end
        end
        // data model
        if (tb_mem_clr) begin
            for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
            m_mem_ok = 1'b1;
            m_rd_ok  = 1'b0;
        end else begin
            rd_next = m_mem[e_addr[3:0]];
            if (e_w) m_mem[e_addr[3:0]] = e_wdata;
            m_rd    = rd_next;
            m_rd_ok = m_mem_ok;
        end
        // ownership model
        if (!Resetn) begin
            m_mode  = MD_RUN;
            m_block = 1'b0;
            m_valid = 1'b0;
        end else begin
            m_valid = e_gnt && !bus.H_W;
            case (m_mode)
                MD_RUN: begin
                    go = bus.H_Req && !m_block;
                    if (!bus.P_Idle || !bus.Run_in) m_block = 1'b0;
                    if (go) m_mode = MD_WAIT;
                end
                MD_WAIT: begin
                    if (!bus.H_Req) m_mode = MD_RUN;
                    else if (bus.P_Idle && !bus.P_W) begin
                        m_mode = MD_SERVE;
                        m_left = BURST;
                    end
                end
                default: begin
                    if (!bus.H_Req) m_mode = MD_RUN;
                    else begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_mode  = MD_RUN;
                            m_block = 1'b1;
                        end
                    end
                end
            endcase
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic set_idle_bus();
        bus.Run_in  = 1'b1;
        bus.P_Idle  = 1'b0;
        bus.P_ADDR  = 16'h0000;
        bus.P_DOUT  = 16'h0000;
        bus.P_W     = 1'b0;
        bus.H_Req   = 1'b0;
        bus.H_W     = 1'b0;
        bus.H_ADDR  = 16'h0000;
        bus.H_WDATA = 16'h0000;
    endtask

    task automatic rand_proc();
        bus.P_ADDR = {12'($urandom_range(0, 4095)), 4'($urandom_range(0, 15))};
        bus.P_DOUT = 16'($urandom);
    endtask

    initial begin
        int hold_cnt;
        n_checks = 0; n_errors = 0; n_gnt_seen = 0;
        m_mode = MD_RUN; m_left = 0; m_block = 1'b0; m_valid = 1'b0;
        m_rd = 16'h0000; m_rd_ok = 1'b0; m_mem_ok = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
        set_idle_bus();
        Resetn = 1'b0;
        tb_mem_clr = 1'b1;
        @(posedge Clock);
        #1;
        tick(1'b0);
        tb_mem_clr = 1'b0;
        tick(1'b1);
        Resetn = 1'b1;

        // Idle host: processor owns memory and runs
        for (int c = 0; c < 6; c++) begin
            rand_proc();
            bus.P_W = 1'($urandom_range(0, 1));
            tick(1'b1);
        end

        // Host request while processor busy for 4 cycles
        bus.P_W = 1'b0;
        bus.H_Req = 1'b1;
        bus.P_Idle = 1'b0;
        for (int c = 0; c < 5; c++) tick(1'b1);
        chk_val("drain_runout", 16'(bus.Run_out), 16'h0000);
        // Idle but a store still trailing
        bus.P_Idle = 1'b1;
        bus.P_W = 1'b1;
        bus.P_ADDR = 16'h0003;
        bus.P_DOUT = 16'hBEEF;
        tick(1'b1);
        bus.P_W = 1'b0;
        tick(1'b1);
        chk_val("host_gnt", 16'(bus.H_Gnt), 16'h0001);
        // Host write then read of 0x0040
        bus.H_W = 1'b1;
        bus.H_ADDR = 16'h0040;
        bus.H_WDATA = 16'h1234;
        tick(1'b1);
        bus.H_W = 1'b0;
        tick(1'b1);
        bus.H_Req = 1'b0;
        chk_val("rd_valid", 16'(bus.H_Valid), 16'h0001);
        chk_val("rd_data", bus.H_RDATA, 16'h1234);
        tick(1'b1);

        // Long request: burst limit then hold-off
        bus.P_Idle = 1'b0;
        tick(1'b1);
        bus.P_Idle = 1'b1;
        bus.H_Req = 1'b1;
        n_gnt_seen = 0;
        for (int c = 0; c < 20; c++) tick(1'b1);
        chk_val("burst_grants", 16'(n_gnt_seen), 16'(BURST));
        bus.P_Idle = 1'b0;
        tick(1'b1);
        bus.P_Idle = 1'b1;
        n_gnt_seen = 0;
        for (int c = 0; c < 4; c++) tick(1'b1);
        chk_val("regrant", 16'(n_gnt_seen), 16'h0002);

        // Reset in the middle of a host burst (reading)
        Resetn = 1'b0;
        tick(1'b1);
        Resetn = 1'b1;
        chk_val("rst_gnt", 16'(bus.H_Gnt), 16'h0000);
        chk_val("rst_valid", 16'(bus.H_Valid), 16'h0000);
        chk_val("rst_runout", 16'(bus.Run_out), 16'(bus.Run_in));
        tick(1'b1);
        bus.H_Req = 1'b0;
        hold_cnt = 0;
        while (m_mode != MD_RUN && hold_cnt < 20) begin
            tick(1'b1);
            hold_cnt++;
        end
        chk_val("return_proc", 16'(m_mode == MD_RUN), 16'h0001);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) bus.H_Req = ~bus.H_Req;
            bus.H_W     = 1'($urandom_range(0, 1));
            bus.H_ADDR  = {12'($urandom_range(0, 4095)), 4'($urandom_range(0, 15))};
            bus.H_WDATA = 16'($urandom);
            bus.P_Idle  = ($urandom_range(0, 1) == 0);
            bus.P_W     = ($urandom_range(0, 3) == 0);
            bus.Run_in  = ($urandom_range(0, 15) != 0);
            Resetn      = ($urandom_range(0, 199) != 0);
            rand_proc();
            tick(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/proc_mem_arbiter.md
PROC_MEM_ARBITER -- requirements
Module: proc_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8: maximum host accesses per grant before memory returns to processor.
REQ-002 SHALL have Clock  input  1  rising-edge clock.
REQ-003 SHALL have Resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have Run_in  input  1  external run request.
REQ-005 SHALL have Run_out  output  1  Run to processor.
REQ-006 SHALL have P_Idle  input  1  processor in fetch step T0.
REQ-007 SHALL have P_ADDR  input  16  processor address register.
REQ-008 SHALL have P_DOUT  input  16  processor write data.
REQ-009 SHALL have P_W  input  1  processor write strobe, registered.
REQ-010 SHALL have P_DIN  output  16  read data to processor.
REQ-011 SHALL have H_Req  input  1  host access request, level.
REQ-012 SHALL have H_W  input  1  host write when 1, read when 0.
REQ-013 SHALL have H_ADDR  input  16  host address.
REQ-014 SHALL have H_WDATA  input  16  host write data.
REQ-015 SHALL have H_Gnt  output  1  host access accepted this cycle.
REQ-016 SHALL have H_Valid  output  1  H_RDATA valid this cycle.
REQ-017 SHALL have H_RDATA  output  16  read data to host.
REQ-018 SHALL have M_ADDR, M_WDATA (output 16), M_W (output 1), M_RDATA (input 16): synchronous memory port, 1-cycle read latency.

Function
REQ-019 SHALL implement FSM states PROC, DRAIN, HOST.
REQ-020 SHALL, in PROC and DRAIN, drive M_ADDR=P_ADDR, M_WDATA=P_DOUT, M_W=P_W; in HOST, M_ADDR=H_ADDR, M_WDATA=H_WDATA, M_W=H_Gnt&H_W.
REQ-021 SHALL drive P_DIN=M_RDATA and H_RDATA=M_RDATA combinationally in all states.
REQ-022 SHALL drive Run_out=Run_in in PROC, 0 in DRAIN and HOST.
REQ-023 SHALL go PROC->DRAIN when H_Req=1 and hold-off flag clear; Run_out drops in the DRAIN cycle.
REQ-024 SHALL go DRAIN->HOST only when P_Idle=1 and P_W=0 in the same cycle (pending processor store completes first); else remain DRAIN.
REQ-025 SHALL, in HOST, assert H_Gnt=H_Req; each granted cycle performs exactly one access and increments burst counter.
REQ-026 SHALL register H_Valid = H_Gnt&~H_W, asserting exactly one cycle after a granted read regardless of next state.
REQ-027 SHALL go HOST->PROC when H_Req=0, or when the granted access brings the burst count to MAX_BURST; count clears on entering HOST.
REQ-028 SHALL set hold-off flag on burst-limit exit; flag clears when P_Idle=0 observed or Run_in=0; H_Req=1 while flag set stays in PROC.
REQ-029 SHALL never assert H_Gnt outside HOST; H_Req dropping in DRAIN returns to PROC next cycle.
REQ-030 SHALL ignore Run_in changes in DRAIN/HOST; Run_in sampled again on PROC entry.

Reset
REQ-031 SHALL on Resetn=0 at a clock edge enter PROC, clear burst count, hold-off flag, H_Valid; H_Gnt=0, Run_out=Run_in after reset.
REQ-032 SHALL abort a HOST burst on reset mid-operation; no H_Valid for an access granted in the reset cycle.

Verification
REQ-033 Idle host, Run_in=1 -> Run_out=1, M_ADDR tracks P_ADDR every cycle, H_Gnt never 1.
REQ-034 H_Req=1 while P_Idle=0 for 4 cycles then 1 -> DRAIN 4 cycles, Run_out=0, first H_Gnt in cycle after P_Idle=1.
REQ-035 P_Idle=1 with P_W=1 (store trailing) -> DRAIN one extra cycle, M_W=1 with P_ADDR, then HOST.
REQ-036 Host writes 0x1234 to 0x0040 then reads 0x0040 -> H_Valid one cycle after read grant, H_RDATA=0x1234.
REQ-037 H_Req held 20 cycles, MAX_BURST=8 -> exactly 8 grants, return to PROC, no re-grant until P_Idle=0 seen.
REQ-038 Resetn=0 during HOST burst -> next cycle PROC, H_Gnt=0, H_Valid=0, count 0.
